// File: rtl/mem_port_arbiter.sv
// Arbitrates load requests and committed-store drains onto one memory port.
// Ports: ld_req_*/st_req_* in, mem_req_*/mem_resp_* memory side, ld_resp_* out.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TW         = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req_valid,
  output logic          ld_req_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [TW-1:0] ld_tag,
  input  logic          st_req_valid,
  output logic          st_req_ready,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  input  logic          sq_full,
  input  logic          flush,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_resp_valid,
  input  logic [DW-1:0] mem_resp_rdata,
  output logic          ld_resp_valid,
  output logic [DW-1:0] ld_resp_data,
  output logic [TW-1:0] ld_resp_tag
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RD
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [SW-1:0] r_starve;
  logic          r_kill;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [TW-1:0] r_tag;
  logic          r_resp_v;
  logic [DW-1:0] r_resp_d;
  logic [TW-1:0] r_resp_t;

  logic w_idle;
  logic w_starved;
  logic w_st_win;
  logic w_st_go;
  logic w_ld_go;
  logic w_deliver;
  logic w_kill_set;

  assign w_idle    = (r_state == IDLE);
  assign w_starved = (r_starve == SW'(STARVE_MAX));

  // Store takes the port when the queue is backing up, when loads
  // have starved it long enough, or when there is no load at all.
  assign w_st_win = st_req_valid &
                    (sq_full | w_starved | ~ld_req_valid);

  assign st_req_ready = w_idle & w_st_win;
  assign ld_req_ready = w_idle & ld_req_valid &
                        ~w_st_win & ~flush;

  assign w_st_go = st_req_valid & st_req_ready;
  assign w_ld_go = ld_req_valid & ld_req_ready;

  // A flush in the response cycle kills that response too.
  assign w_kill_set = flush &
                      (((r_state == REQ) & ~r_we) |
                       (r_state == WAIT_RD));
  assign w_deliver  = (r_state == WAIT_RD) & mem_resp_valid &
                      ~r_kill & ~flush;

  assign mem_req_valid = (r_state == REQ);
  assign mem_req_we    = r_we;
  assign mem_req_addr  = r_addr;
  assign mem_req_wdata = r_wdata;
  assign ld_resp_valid = r_resp_v;
  assign ld_resp_data  = r_resp_d;
  assign ld_resp_tag   = r_resp_t;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_st_go | w_ld_go) w_state_nxt = REQ;
      end
      REQ: begin
        // Stores are posted: no read data to wait for.
        if (mem_req_ready) begin
          w_state_nxt = r_we ? IDLE : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (mem_resp_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_tag   <= '0;
    end else if (w_st_go) begin
      r_we    <= 1'b1;
      r_addr  <= st_addr;
      r_wdata <= st_data;
    end else if (w_ld_go) begin
      r_we    <= 1'b0;
      r_addr  <= ld_addr;
      r_wdata <= '0;
      r_tag   <= ld_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= '0;
    end else if (w_st_go) begin
      r_starve <= '0;
    end else if (w_ld_go & st_req_valid & ~w_starved) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_kill <= 1'b0;
    end else if (w_ld_go) begin
      r_kill <= 1'b0;
    end else if (w_kill_set) begin
      r_kill <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_v <= 1'b0;
      r_resp_d <= '0;
      r_resp_t <= '0;
    end else begin
      r_resp_v <= w_deliver;
      if (w_deliver) begin
        r_resp_d <= mem_resp_rdata;
        r_resp_t <= r_tag;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter AW, 32, address width (matches `ADDR_WIDTH`) SHALL be provided.
REQ-002 Parameter DW, 32, data width (matches `DATA_WIDTH`) SHALL be provided.
REQ-003 Parameter TW, 4, load tag width (ROB index, matches `ROB_SEL`) SHALL be provided.
REQ-004 Parameter STARVE_MAX, 4, consecutive store-losing load grants before store priority SHALL be provided.
REQ-005 Ports SHALL be, in order:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ld_req_valid / ld_req_ready  in / out  1 / 1  load request handshake
- ld_addr  in  AW  load address
- ld_tag  in  TW  load ROB tag
- st_req_valid / st_req_ready  in / out  1 / 1  committed-store drain handshake from store queue
- st_addr  in  AW  store address
- st_data  in  DW  store data
- sq_full  in  1  store queue full hint
- flush  in  1  pipeline flush; kills in-flight load
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write
- mem_req_addr  out  AW  memory address
- mem_req_wdata  out  DW  memory write data
- mem_resp_valid  in  1  read data return
- mem_resp_rdata  in  DW  read data
- ld_resp_valid  out  1  load data valid, one-cycle pulse
- ld_resp_data  out  DW  load data
- ld_resp_tag  out  TW  tag of returned load

Function
REQ-006 FSM states SHALL be IDLE, REQ, WAIT_RD; at most one memory transaction outstanding.
REQ-007 In IDLE, ld_req_ready and st_req_ready SHALL be combinational grant outputs, at most one high; both 0 outside IDLE.
REQ-008 Grant rule: store wins if st_req_valid and (sq_full or starve_cnt == STARVE_MAX) or ld_req_valid low; otherwise load wins.
REQ-009 Load SHALL NOT be granted in a cycle where flush = 1; store grant unaffected by flush.
REQ-010 starve_cnt: saturating at STARVE_MAX; +1 on load grant while st_req_valid = 1; cleared on store grant; unchanged otherwise.
REQ-011 On accepted grant (valid & ready at edge), request fields SHALL be registered and state SHALL go REQ next cycle with mem_req_valid = 1.
REQ-012 In REQ, mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata SHALL hold stable until mem_req_ready = 1.
REQ-013 REQ with mem_req_ready: store -> IDLE (posted write, no response); load -> WAIT_RD.
REQ-014 mem_req_wdata SHALL be 0 for loads; mem_req_we = 0 for loads, 1 for stores.
REQ-015 WAIT_RD with mem_resp_valid SHALL go IDLE; ld_resp_valid SHALL pulse for one cycle on the next cycle with ld_resp_data = captured rdata and ld_resp_tag = captured tag, unless killed.
REQ-016 flush = 1 in any cycle while a load is in REQ or WAIT_RD (or in the accepting edge's cycle, excluded by REQ-009) SHALL set a kill flag; killed load completes its memory handshake but ld_resp_valid SHALL stay 0.
REQ-017 mem_resp_valid outside WAIT_RD SHALL be ignored.
REQ-018 Minimum latency: load grant at cycle N -> mem_req_valid at N+1 -> (ready at N+1, resp at N+2) -> ld_resp_valid at N+3.
REQ-019 Back-to-back: new grant SHALL be possible in the first IDLE cycle after return to IDLE.

Reset
REQ-020 On reset low, asynchronously: state IDLE, starve_cnt 0, kill flag 0, mem_req_valid 0, mem_req_we 0, mem_req_addr 0, mem_req_wdata 0, ld_resp_valid 0, ld_resp_data 0, ld_resp_tag 0.
REQ-021 Reset mid-transaction SHALL abandon it; no ld_resp_valid after reset release for the abandoned load.

Verification
REQ-022 Load only: ld_addr=0x100, tag=3, mem ready immediately, rdata=0xDEADBEEF one cycle later -> ld_resp_valid pulse, data 0xDEADBEEF, tag 3, 3 cycles after grant.
REQ-023 Store only: st_addr=0x200, st_data=0x12345678, mem_req_ready delayed 3 cycles -> mem_req_we=1, fields stable 4 cycles, return IDLE, no ld_resp_valid.
REQ-024 Starvation: continuous load and store valid, sq_full=0 -> 4 load grants then 1 store grant, starve_cnt cleared, pattern repeats.
REQ-025 sq_full=1 with both valid -> store granted first cycle regardless of starve_cnt.
REQ-026 Flush during WAIT_RD of tag 5 -> memory response consumed, ld_resp_valid stays 0, next request granted normally.
REQ-027 reset low during REQ of a load -> all outputs zero immediately; after release with no requests, mem_req_valid and ld_resp_valid remain 0.
